stereo_fft_scheduler: RTL and testbench

Sequencer that time-shares the single FFT compiler between the left and right audio channels. For each frame it arbitrates between channel requests, issues Start, and gates sample strobes and data into the compiler. It then waits for FFT completion and sweeps ReadAddr over the half-spectrum. Output is a latency-aligned bin stream tagged with bin index and channel, consumed by the display/magnitude stage.

---
 rtl/stereo_fft_scheduler_pkg.sv | 32 +++
 rtl/stereo_fft_scheduler_tagger.sv | 77 +++++++
 rtl/stereo_fft_scheduler.sv | 153 +++++++++++++++
 tb/tb_stereo_fft_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_fft_scheduler_pkg.sv
// Shared types and constants for the stereo FFT scheduler.
// Channel encoding doubles as the OutCh / GrantCh value.
package stereo_fft_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CAPTURE,
        S_FFT_WAIT,
        S_RD_WAIT,
        S_READOUT,
        S_DRAIN
    } state_t;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    localparam int Q_LATENCY = 3;

    // On a tie the channel not served last wins.
    function automatic logic pickChannel(
        input logic reqL,
        input logic reqR,
        input logic lastServed
    );
        if (reqL && reqR) begin
            return ~lastServed;
        end
        return reqR ? CH_R : CH_L;
    endfunction

endpackage

// File: rtl/stereo_fft_scheduler_tagger.sv
// Readout address counter plus the {valid, bin, last} delay line
// that lines tags up with compiler Q data, then registers the bin.
module fft_read_tagger
    import stereo_fft_scheduler_pkg::*;
#(
    parameter int bw_fftp   = 12,
    parameter int bw_data   = 18,
    parameter int read_bins = 2048,
    parameter int q_latency = Q_LATENCY
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    output logic [bw_fftp-1:0] ReadAddr,
    output logic               IssueLast,
    input  logic [bw_data-1:0] QRe,
    input  logic [bw_data-1:0] QIm,
    output logic               OutValid,
    output logic [bw_fftp-1:0] OutBin,
    output logic [bw_data-1:0] OutRe,
    output logic [bw_data-1:0] OutIm,
    output logic               OutLast
);

    localparam logic [bw_fftp-1:0] LastAddr = bw_fftp'(read_bins - 1);

    logic [q_latency-1:0]              tagValid;
    logic [q_latency-1:0]              tagLast;
    logic [q_latency-1:0][bw_fftp-1:0] tagBin;
    logic                              tapValid;

    assign IssueLast = Run && (ReadAddr == LastAddr);
    assign tapValid  = tagValid[q_latency-1];

    always_ff @(posedge Clock) begin
        if (Reset || IssueLast) begin
            ReadAddr <= '0;
        end else if (Run) begin
            ReadAddr <= ReadAddr + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tagValid <= '0;
            tagLast  <= '0;
            tagBin   <= '0;
        end else begin
            tagValid[0] <= Run;
            tagLast[0]  <= IssueLast;
            tagBin[0]   <= ReadAddr;
            for (int i = 1; i < q_latency; i++) begin
                tagValid[i] <= tagValid[i-1];
                tagLast[i]  <= tagLast[i-1];
                tagBin[i]   <= tagBin[i-1];
            end
        end
    end

    // Last tap is aligned with the compiler's Q for that address.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            OutBin   <= '0;
            OutRe    <= '0;
            OutIm    <= '0;
        end else begin
            OutValid <= tapValid;
            OutLast  <= tapValid && tagLast[q_latency-1];
            OutBin   <= tapValid ? tagBin[q_latency-1] : '0;
            OutRe    <= tapValid ? QRe : '0;
            OutIm    <= tapValid ? QIm : '0;
        end
    end

endmodule

// File: rtl/stereo_fft_scheduler.sv
// Time-shares one FFT compiler between left and right channels:
// arbitrate, capture, wait for the transform, stream the half-spectrum.
module stereo_fft_scheduler
    import stereo_fft_scheduler_pkg::*;
#(
    parameter int bw_fftp    = 12,
    parameter int bw_data    = 18,
    parameter int read_bins  = 2048,
    parameter int q_latency  = Q_LATENCY,
    parameter int bw_timeout = 20
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               FrameReq_L,
    input  logic               FrameReq_R,
    input  logic               SampleCE,
    input  logic [15:0]        InData_L,
    input  logic [15:0]        InData_R,
    input  logic               SinkReady,
    output logic               FrameAck_L,
    output logic               FrameAck_R,
    output logic               FFT_Start,
    output logic               FFT_CEInput,
    output logic [15:0]        FFT_InData,
    output logic [bw_fftp-1:0] FFT_ReadAddr,
    input  logic               FFT_InputEnd,
    input  logic               FFT_FFTEnd,
    input  logic               FFT_ReadAddrValid,
    input  logic [bw_data-1:0] FFT_Q_Re,
    input  logic [bw_data-1:0] FFT_Q_Im,
    output logic               OutValid,
    output logic               OutCh,
    output logic [bw_fftp-1:0] OutBin,
    output logic [bw_data-1:0] OutRe,
    output logic [bw_data-1:0] OutIm,
    output logic               OutLast,
    output logic               Busy,
    output logic               Error
);

    state_t                  state;
    state_t                  stateNext;
    logic                    grantCh;
    logic                    lastServed;
    logic                    anyReq;
    logic                    issueLast;
    logic                    wdFull;
    logic [bw_timeout-1:0]   wdCount;

    assign anyReq = FrameReq_L || FrameReq_R;
    assign wdFull = &wdCount;
    assign OutCh  = grantCh;

    fft_read_tagger #(
        .bw_fftp  (bw_fftp),
        .bw_data  (bw_data),
        .read_bins(read_bins),
        .q_latency(q_latency)
    ) u_tagger (
        .Clock    (Clock),
        .Reset    (Reset),
        .Run      (state == S_READOUT),
        .ReadAddr (FFT_ReadAddr),
        .IssueLast(issueLast),
        .QRe      (FFT_Q_Re),
        .QIm      (FFT_Q_Im),
        .OutValid (OutValid),
        .OutBin   (OutBin),
        .OutRe    (OutRe),
        .OutIm    (OutIm),
        .OutLast  (OutLast)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Awaited pulses take priority over watchdog expiry.
    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE:     if (anyReq) stateNext = S_START;
            S_START:    stateNext = S_CAPTURE;
            S_CAPTURE: begin
                if (FFT_InputEnd)  stateNext = S_FFT_WAIT;
                else if (wdFull)   stateNext = S_IDLE;
            end
            S_FFT_WAIT: begin
                if (FFT_FFTEnd)    stateNext = S_RD_WAIT;
                else if (wdFull)   stateNext = S_IDLE;
            end
            S_RD_WAIT: begin
                if (FFT_ReadAddrValid && SinkReady) begin
                    stateNext = S_READOUT;
                end
            end
            S_READOUT:  if (issueLast) stateNext = S_DRAIN;
            S_DRAIN:    if (OutLast) stateNext = S_IDLE;
            default:    stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        Busy        = (state != S_IDLE);
        FFT_Start   = (state == S_START);
        FFT_CEInput = 1'b0;
        FFT_InData  = 16'd0;
        FrameAck_L  = 1'b0;
        FrameAck_R  = 1'b0;
        Error       = 1'b0;
        unique case (state)
            S_CAPTURE: begin
                FFT_CEInput = SampleCE;
                FFT_InData  = grantCh ? InData_R : InData_L;
                Error       = wdFull && !FFT_InputEnd;
            end
            S_FFT_WAIT: Error = wdFull && !FFT_FFTEnd;
            S_DRAIN: begin
                FrameAck_L = OutLast && (grantCh == CH_L);
                FrameAck_R = OutLast && (grantCh == CH_R);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            grantCh    <= CH_L;
            lastServed <= CH_R;
        end else begin
            if (state == S_IDLE && anyReq) begin
                grantCh <= pickChannel(FrameReq_L, FrameReq_R, lastServed);
            end
            if (state == S_DRAIN && OutLast) begin
                lastServed <= grantCh;
            end
        end
    end

    // Only capture and transform time are bounded; sink stalls are legal.
    always_ff @(posedge Clock) begin
        if (Reset || state != stateNext) begin
            wdCount <= '0;
        end else if (state == S_CAPTURE || state == S_FFT_WAIT) begin
            wdCount <= wdCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_stereo_fft_scheduler.sv
// Bench for stereo_fft_scheduler: behavioural FFT compiler model
// plus a per-frame scoreboard of expected channels and bins.
module tb_stereo_fft_scheduler;
    import stereo_fft_scheduler_pkg::*;

    localparam int BW_FFTP     = 12;
    localparam int BW_DATA     = 18;
    localparam int READ_BINS   = 2048;
    localparam int BW_TIMEOUT  = 10;
    localparam int CAP_SAMPLES = 16;
    localparam int FFT_DELAY   = 20;

    logic               Clock;
    logic               Reset;
    logic               FrameReq_L, FrameReq_R;
    logic               SampleCE;
    logic [15:0]        InData_L, InData_R;
    logic               SinkReady;
    logic               FrameAck_L, FrameAck_R;
    logic               FFT_Start, FFT_CEInput;
    logic [15:0]        FFT_InData;
    logic [BW_FFTP-1:0] FFT_ReadAddr;
    logic               FFT_InputEnd, FFT_FFTEnd, FFT_ReadAddrValid;
    logic [BW_DATA-1:0] FFT_Q_Re, FFT_Q_Im;
    logic               OutValid, OutCh, OutLast, Busy, Error;
    logic [BW_FFTP-1:0] OutBin;
    logic [BW_DATA-1:0] OutRe, OutIm;

    stereo_fft_scheduler #(
        .bw_fftp   (BW_FFTP),
        .bw_data   (BW_DATA),
        .read_bins (READ_BINS),
        .q_latency (3),
        .bw_timeout(BW_TIMEOUT)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .FrameReq_L       (FrameReq_L),
        .FrameReq_R       (FrameReq_R),
        .SampleCE         (SampleCE),
        .InData_L         (InData_L),
        .InData_R         (InData_R),
        .SinkReady        (SinkReady),
        .FrameAck_L       (FrameAck_L),
        .FrameAck_R       (FrameAck_R),
        .FFT_Start        (FFT_Start),
        .FFT_CEInput      (FFT_CEInput),
        .FFT_InData       (FFT_InData),
        .FFT_ReadAddr     (FFT_ReadAddr),
        .FFT_InputEnd     (FFT_InputEnd),
        .FFT_FFTEnd       (FFT_FFTEnd),
        .FFT_ReadAddrValid(FFT_ReadAddrValid),
        .FFT_Q_Re         (FFT_Q_Re),
        .FFT_Q_Im         (FFT_Q_Im),
        .OutValid         (OutValid),
        .OutCh            (OutCh),
        .OutBin           (OutBin),
        .OutRe            (OutRe),
        .OutIm            (OutIm),
        .OutLast          (OutLast),
        .Busy             (Busy),
        .Error            (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [84:0] outsVec;
    assign outsVec = {FrameAck_L, FrameAck_R, FFT_Start, FFT_CEInput,
                      FFT_InData, FFT_ReadAddr, OutValid, OutCh, OutBin,
                      OutRe, OutIm, OutLast, Busy, Error};

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Sample source, changed well away from both clock edges.
    always @(posedge Clock) begin
        #2;
        SampleCE = ~SampleCE;
        InData_L = 16'($urandom);
        InData_R = 16'($urandom);
    end

    // FFT compiler model.
    logic               capActive, fftRun, capCh, noInputEnd;
    int                 capCnt, fftCnt;
    int                 startsSeen = 0, fftEndSeen = 0;
    logic [BW_FFTP-1:0] d1, d2, d3;
    logic               startQ[$];

    always @(posedge Clock) begin
        d1 <= FFT_ReadAddr;
        d2 <= d1;
        d3 <= d2;
        FFT_InputEnd <= 1'b0;
        FFT_FFTEnd   <= 1'b0;
        if (Reset) begin
            capActive <= 1'b0;
            fftRun    <= 1'b0;
            capCnt    <= 0;
            fftCnt    <= 0;
            FFT_ReadAddrValid <= 1'b0;
            startQ.delete();
        end else begin
            if (FFT_Start) begin
                startsSeen <= startsSeen + 1;
                capActive  <= 1'b1;
                capCnt     <= 0;
                FFT_ReadAddrValid <= 1'b0;
                if (startQ.size() > 0) capCh <= startQ.pop_front();
                else capCh <= 1'b0;
            end
            if (capActive && FFT_CEInput) begin
                capCnt <= capCnt + 1;
                if (capCnt == CAP_SAMPLES - 1 && !noInputEnd)
                    FFT_InputEnd <= 1'b1;
            end
            if (FFT_InputEnd) begin
                capActive <= 1'b0;
                fftRun    <= 1'b1;
                fftCnt    <= 0;
            end
            if (Error) capActive <= 1'b0;
            if (fftRun) begin
                fftCnt <= fftCnt + 1;
                if (fftCnt == FFT_DELAY - 1) begin
                    FFT_FFTEnd <= 1'b1;
                    fftRun     <= 1'b0;
                end
            end
            if (FFT_FFTEnd) begin
                FFT_ReadAddrValid <= 1'b1;
                fftEndSeen <= fftEndSeen + 1;
            end
        end
    end

    assign FFT_Q_Re = 18'(d3) + 18'd5;
    assign FFT_Q_Im = 18'(d3) ^ 18'h2AAAA;

    // Scoreboard: expected channel per frame, bins checked in order.
    logic               chQ[$];
    logic               ackQ[$];
    logic               expCh;
    logic [1:0]         expAck;
    int                 beat = 0;
    int                 ackCnt = 0, errCnt = 0, tAddr1 = 0;
    logic [BW_FFTP-1:0] prevAddr = '0;

    always @(negedge Clock) begin
        if (Reset) begin
            beat = 0;
            chQ.delete();
            ackQ.delete();
        end else begin
            if (capActive)
                checkEq("capture", {FFT_CEInput, FFT_InData},
                        {SampleCE, capCh ? InData_R : InData_L});
            if (FFT_ReadAddr == 12'd1 && prevAddr == 12'd0) tAddr1 = cyc;
            prevAddr = FFT_ReadAddr;
            if (OutValid) begin
                if (chQ.size() == 0) checkEq("sbUnderflow", 0, 1);
                expCh = (chQ.size() > 0) ? chQ[0] : 1'b0;
                if (beat == 0) checkEq("latency", cyc - tAddr1, 3);
                checkEq("beat", {OutCh, OutBin, OutRe, OutIm, OutLast},
                        {expCh, 12'(beat), 18'(beat + 5),
                         18'(beat) ^ 18'h2AAAA, beat == READ_BINS - 1});
                if (beat == READ_BINS - 1) begin
                    beat = 0;
                    if (chQ.size() > 0) chQ.delete(0);
                    ackQ.push_back(expCh);
                end else begin
                    beat++;
                end
            end else if (beat != 0) begin
                checkEq("gap", OutValid, 1);
            end
            if (FrameAck_L || FrameAck_R) begin
                expAck = (ackQ.size() > 0) ? (ackQ[0] ? 2'b10 : 2'b01) : 2'b00;
                if (ackQ.size() > 0) ackQ.delete(0);
                checkEq("ack", {FrameAck_R, FrameAck_L}, expAck);
                ackCnt++;
            end
            if (Error) errCnt++;
        end
    end

    task automatic doReset(input int n);
        Reset = 1'b1;
        repeat (n) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic waitStarts(input int n, input int budget);
        int k = 0;
        while (startsSeen < n && k < budget) begin
            @(negedge Clock);
            k++;
        end
        if (startsSeen < n) checkEq("startTimeout", startsSeen, n);
    endtask

    task automatic waitAcks(input int n, input int budget);
        int k = 0;
        while (ackCnt < n && k < budget) begin
            @(negedge Clock);
            k++;
        end
        if (ackCnt < n) checkEq("ackTimeout", ackCnt, n);
    endtask

    task automatic frame(input logic ch);
        startQ.push_back(ch);
        chQ.push_back(ch);
    endtask

    int base, ackBase, errBase, tStart, tErr, k;

    initial begin
        Reset = 1'b1;
        FrameReq_L = 1'b0;
        FrameReq_R = 1'b0;
        SinkReady = 1'b1;
        SampleCE = 1'b0;
        InData_L = '0;
        InData_R = '0;
        noInputEnd = 1'b0;
        repeat (3) @(negedge Clock);
        checkEq("resetOuts", outsVec, 0);
        Reset = 1'b0;
        @(negedge Clock);
        checkEq("idleOuts", outsVec, 0);

        // Single left frame.
        base = startsSeen;
        ackBase = ackCnt;
        frame(CH_L);
        FrameReq_L = 1'b1;
        waitStarts(base + 1, 50);
        FrameReq_L = 1'b0;
        waitAcks(ackBase + 1, 4000);
        repeat (5) @(negedge Clock);
        checkEq("oneStart", startsSeen - base, 1);
        checkEq("oneAck", ackCnt - ackBase, 1);

        // Both requests held from reset: L, R, L, R.
        doReset(2);
        base = startsSeen;
        ackBase = ackCnt;
        frame(CH_L);
        frame(CH_R);
        frame(CH_L);
        frame(CH_R);
        FrameReq_L = 1'b1;
        FrameReq_R = 1'b1;
        waitStarts(base + 4, 12000);
        FrameReq_L = 1'b0;
        FrameReq_R = 1'b0;
        waitAcks(ackBase + 4, 4000);
        repeat (5) @(negedge Clock);
        checkEq("fourStarts", startsSeen - base, 4);

        // Sink stall in RD_WAIT, then a drop mid-burst.
        base = startsSeen;
        ackBase = ackCnt;
        k = fftEndSeen;
        frame(CH_R);
        SinkReady = 1'b0;
        FrameReq_R = 1'b1;
        waitStarts(base + 1, 50);
        FrameReq_R = 1'b0;
        for (int i = 0; i < 300 && fftEndSeen == k; i++) @(negedge Clock);
        checkEq("fftEnd", fftEndSeen - k, 1);
        for (int i = 0; i < 100; i++) begin
            checkEq("stall", {Busy, Error, FFT_ReadAddr, OutValid},
                    {1'b1, 1'b0, 12'd0, 1'b0});
            @(negedge Clock);
        end
        SinkReady = 1'b1;
        repeat (600) @(negedge Clock);
        SinkReady = 1'b0;
        waitAcks(ackBase + 1, 4000);
        SinkReady = 1'b1;
        repeat (5) @(negedge Clock);

        // Watchdog: capture never completes.
        ackBase = ackCnt;
        errBase = errCnt;
        noInputEnd = 1'b1;
        startQ.push_back(CH_L);
        FrameReq_L = 1'b1;
        for (k = 0; k < 20 && !FFT_Start; k++) @(negedge Clock);
        checkEq("wdStart", FFT_Start, 1);
        tStart = cyc;
        FrameReq_L = 1'b0;
        for (k = 0; k < 2000 && !Error; k++) @(negedge Clock);
        tErr = cyc;
        checkEq("wdDelay", tErr - tStart, 1024);
        @(negedge Clock);
        checkEq("wdBusy", Busy, 0);
        repeat (20) @(negedge Clock);
        checkEq("wdErrCnt", errCnt - errBase, 1);
        checkEq("wdNoAck", ackCnt - ackBase, 0);
        noInputEnd = 1'b0;

        // Reset in the middle of a readout burst.
        base = startsSeen;
        ackBase = ackCnt;
        frame(CH_L);
        FrameReq_L = 1'b1;
        waitStarts(base + 1, 50);
        FrameReq_L = 1'b0;
        for (k = 0; k < 3000 && FFT_ReadAddr != 12'd1000; k++)
            @(negedge Clock);
        checkEq("reachBin1000", FFT_ReadAddr, 1000);
        Reset = 1'b1;
        @(negedge Clock);
        checkEq("abortOuts", outsVec, 0);
        Reset = 1'b0;
        @(negedge Clock);
        repeat (10) @(negedge Clock);
        checkEq("abortNoAck", ackCnt - ackBase, 0);
        frame(CH_R);
        FrameReq_R = 1'b1;
        waitStarts(base + 2, 50);
        FrameReq_R = 1'b0;
        waitAcks(ackBase + 1, 4000);
        repeat (10) @(negedge Clock);

        checkEq("sbEmpty", chQ.size(), 0);
        checkEq("ackQEmpty", ackQ.size(), 0);
        checkEq("errTotal", errCnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
